// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: command encodings, the
// divide-by-zero result pattern, sequencer state codes and the queued
// operation record.
package alu_pkg;

    // ALU command encodings as seen on alu_command
    typedef enum logic [3:0] {
        CMD_ADD  = 4'b0000,
        CMD_INC  = 4'b0001,
        CMD_SUB  = 4'b0010,   // b - a
        CMD_DEC  = 4'b0011,
        CMD_MUL  = 4'b0100,
        CMD_DIV  = 4'b0101,
        CMD_SHR  = 4'b0110,
        CMD_SHL  = 4'b0111,
        CMD_AND  = 4'b1000,
        CMD_OR   = 4'b1001,
        CMD_NOT  = 4'b1010,
        CMD_NAND = 4'b1011,
        CMD_NOR  = 4'b1100,
        CMD_XOR  = 4'b1101,
        CMD_XNOR = 4'b1110,
        CMD_BUF  = 4'b1111
    } alu_cmd_e;

    // Result reported for a trapped divide-by-zero
    localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;

    // Sequencer state codes, kept as plain constants so older tools that
    // dislike enums in state registers can still read them
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_DRIVE = 2'd1;
    localparam seq_state_t ST_RESP  = 2'd2;

    // One queued operation
    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

    // A divide with a zero divisor never reaches the ALU
    function automatic logic is_div_zero(input cmd_entry_t e);
        return (e.cmd == CMD_DIV) && (e.b == 8'h00);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Small synchronous FIFO holding operations waiting for the ALU.
// Head entry is visible combinationally on dout; pointers wrap naturally
// because DEPTH is a power of two.
module sync_cmd_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 8-bit ALU. Operations are queued, driven to
// the ALU for exactly one cycle each, and the captured result is held on a
// valid/ready port until taken. Divide-by-zero is answered locally with
// all-ones and an error flag, with the ALU left disabled.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cmd,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [3:0]       alu_command,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic             alu_oe,
    input  logic [15:0]      alu_dout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [3:0]       res_cmd,
    output logic             res_err,
    output logic [LVL_W-1:0] fifo_level
);

    seq_state_t state;
    seq_state_t state_nxt;
    cmd_entry_t in_entry;
    cmd_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       head_div_zero;
    logic       res_taken;

    assign in_entry      = '{cmd: in_cmd, a: in_a, b: in_b};
    assign in_ready      = !fifo_full;
    assign fifo_pop      = (state == ST_DRIVE);
    assign head_div_zero = is_div_zero(head);
    assign res_taken     = res_valid && res_ready;

    sync_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid && in_ready),
        .din   (in_entry),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_level)
    );

    // ALU drive: head operands only while in DRIVE, enable suppressed for a zero divisor
    always_comb begin
        alu_command = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_oe      = 1'b0;
        if (state == ST_DRIVE) begin
            alu_command = head.cmd;
            alu_a       = head.a;
            alu_b       = head.b;
            alu_oe      = !head_div_zero;
        end
    end

    // Next-state selection; RESP only moves on once the consumer takes the result
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (res_taken) begin
                    state_nxt = fifo_empty ? ST_IDLE : ST_DRIVE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result capture at the end of DRIVE, released on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cmd   <= '0;
            res_err   <= 1'b0;
        end else if (state == ST_DRIVE) begin
            res_valid <= 1'b1;
            res_cmd   <= head.cmd;
            if (head_div_zero) begin
                res_data <= DIV_ZERO_RESULT;
                res_err  <= 1'b1;
            end else begin
                res_data <= alu_dout;
                res_err  <= 1'b0;
            end
        end else if (res_taken) begin
            res_valid <= 1'b0;
        end
    end

endmodule
